// File: rtl/rv_multicycle_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv_multicycle_ctrl_pkg                                          |
// | Purpose  : Shared state encodings and trap cause codes for the multi-cycle |
// |            sequencer; the decoder and trap/CSR logic reuse the cause codes.|
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package rv_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] c_cause_illegal = 2'd0;
  localparam logic [1:0] c_cause_ecall   = 2'd1;
  localparam logic [1:0] c_cause_ebreak  = 2'd2;
  localparam logic [1:0] c_cause_bus     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rv_multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv_multicycle_ctrl_if                                           |
// | Purpose  : Groups decoder controls, memory handshakes, trap handshake and  |
// |            datapath enables of the sequencer.                              |
// | Modports : master - the sequencer (consumes dec_*/ready/ack, drives reqs)  |
// |            slave  - decoder/datapath/memory side                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface rv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_en;
  logic             dec_reg_write;
  logic             dec_mem_read;
  logic             dec_mem_write;
  logic             dec_branch;
  logic             dec_jump;
  logic             dec_ecall;
  logic             dec_ebreak;
  logic             dec_illegal;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             trap_ack;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_we;
  logic             pc_we;
  logic             pc_sel;
  logic             trap_valid;
  logic [1:0]       trap_cause;
  logic             busy;
  logic [CNT_W-1:0] instret_count;

  modport master (
    input  run_en, dec_reg_write, dec_mem_read, dec_mem_write, dec_branch,
           dec_jump, dec_ecall, dec_ebreak, dec_illegal, branch_taken,
           imem_ready, dmem_ready, trap_ack,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
           trap_valid, trap_cause, busy, instret_count
  );

  modport slave (
    output run_en, dec_reg_write, dec_mem_read, dec_mem_write, dec_branch,
           dec_jump, dec_ecall, dec_ebreak, dec_illegal, branch_taken,
           imem_ready, dmem_ready, trap_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
           trap_valid, trap_cause, busy, instret_count
  );
endinterface
`default_nettype wire

// File: rtl/rv_multicycle_ctrl_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ctrl_wait_timer                                                 |
// | Purpose  : Saturating wait counter shared by the FETCH and MEM waits.      |
// |            expired_o is high while the count sits at TIMEOUT-1.            |
// | Ports    : clk, rst_n (async active-low), clr_i (highest priority clear),  |
// |            en_i (count up), expired_o                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      expired_o
);
  localparam int             CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  c_max = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != c_max)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == c_max);
endmodule
`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv_multicycle_ctrl                                              |
// | Purpose  : Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with|
// |            trap handling and a retired-instruction counter.                |
// | Ports    : clk, rst_n (async active-low), bus (rv_multicycle_ctrl_if       |
// |            master: decoder controls, imem/dmem handshakes, trap handshake, |
// |            datapath enables, busy, instret_count)                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rv_multicycle_ctrl
  import rv_multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  rv_multicycle_ctrl_if.master bus
);
  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q;
  logic             taken_q;
  logic             w_retire;
  logic             w_expired;
  logic             w_timer_clr;
  logic             w_timer_en;

  // Any state change restarts the wait; only FETCH/MEM accumulate it.
  assign w_timer_clr = (state_d != state_q);
  assign w_timer_en  = (state_q == ST_FETCH) || (state_q == ST_MEM);

  ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (w_timer_clr),
    .en_i      (w_timer_en),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cause_q     <= 2'd0;
      instret_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (w_retire) begin
        instret_q <= instret_q + 1'b1;
      end
      if (state_q == ST_DECODE) begin
        reg_write_q <= bus.dec_reg_write;
        mem_read_q  <= bus.dec_mem_read;
        mem_write_q <= bus.dec_mem_write;
        branch_q    <= bus.dec_branch;
        jump_q      <= bus.dec_jump;
      end
      // Keep the compare result for a branch that continues on to WB.
      if (state_q == ST_EXEC) begin
        taken_q <= bus.branch_taken;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    w_retire       = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_we      = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.rf_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_sel     = 1'b0;
    bus.trap_valid = 1'b0;
    bus.trap_cause = 2'd0;
    bus.busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (bus.run_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_we = 1'b1;
          state_d   = ST_DECODE;
        end else if (w_expired) begin
          state_d = ST_TRAP;
          cause_d = c_cause_bus;
        end
      end
      ST_DECODE: begin
        if (bus.dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = c_cause_illegal;
        end else if (bus.dec_ecall) begin
          state_d = ST_TRAP;
          cause_d = c_cause_ecall;
        end else if (bus.dec_ebreak) begin
          state_d = ST_TRAP;
          cause_d = c_cause_ebreak;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (mem_read_q || mem_write_q) begin
          state_d = ST_MEM;
        end else if (reg_write_q) begin
          state_d = ST_WB;
        end else begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = jump_q | (branch_q & bus.branch_taken);
          w_retire   = 1'b1;
          state_d    = bus.run_en ? ST_FETCH : ST_IDLE;
        end
      end
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = mem_write_q;
        if (bus.dmem_ready) begin
          if (mem_read_q) begin
            state_d = ST_WB;
          end else begin
            bus.pc_we = 1'b1;
            w_retire  = 1'b1;
            state_d   = bus.run_en ? ST_FETCH : ST_IDLE;
          end
        end else if (w_expired) begin
          state_d = ST_TRAP;
          cause_d = c_cause_bus;
        end
      end
      ST_WB: begin
        bus.rf_we  = reg_write_q;
        bus.pc_we  = 1'b1;
        bus.pc_sel = jump_q | (branch_q & taken_q);
        w_retire   = 1'b1;
        state_d    = bus.run_en ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        bus.trap_valid = 1'b1;
        bus.trap_cause = cause_q;
        if (bus.trap_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.instret_count = instret_q;
endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rv_multicycle_ctrl                                           |
// | Purpose  : Self-checking bench: per-instruction expected cycle traces are  |
// |            built from the instruction class and wait counts, then driven   |
// |            and compared cycle by cycle.                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rv_multicycle_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  // Bit positions inside the expected-output vector.
  localparam int E_IMEM = 8, E_IR = 7, E_DREQ = 6, E_DWE = 5, E_RF = 4;
  localparam int E_PCWE = 3, E_PCSEL = 2, E_TRAP = 1, E_BUSY = 0;

  // Instruction classes.
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4;
  localparam int K_NOP = 5, K_ILL = 6, K_ECALL = 7, K_EBRK = 8, K_BRW = 9;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rv_multicycle_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic             run_en, imem_ready, dmem_ready, trap_ack, taken;
    logic             d_rw, d_mr, d_mw, d_br, d_j, d_ec, d_eb, d_il;
    logic [8:0]       exp;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } cyc_t;

  cyc_t             q[$];
  int               checks = 0;
  int               errors = 0;
  int               step   = 0;
  logic [CNT_W-1:0] m_cnt  = '0;

  // A cycle with every input randomised (the ones that matter get overridden)
  // and a busy, otherwise-quiet expectation.
  function automatic cyc_t rnd();
    cyc_t c;
    c = '0;
    {c.run_en, c.imem_ready, c.dmem_ready, c.trap_ack, c.taken} = 5'($urandom);
    {c.d_rw, c.d_mr, c.d_mw, c.d_br, c.d_j, c.d_ec, c.d_eb, c.d_il} = 8'($urandom);
    c.exp    = 9'b0_0000_0001;
    c.cause  = 2'd0;
    c.cnt    = m_cnt;
    return c;
  endfunction

  function automatic cyc_t idle_cyc(input logic re);
    cyc_t c;
    c        = rnd();
    c.run_en = re;
    c.exp    = '0;
    return c;
  endfunction

  task automatic do_trap(input logic [1:0] cause, input int hold);
    cyc_t c;
    for (int k = 0; k < hold; k++) begin
      c = rnd(); c.trap_ack = 1'b0; c.exp[E_TRAP] = 1'b1; c.cause = cause;
      q.push_back(c);
    end
    c = rnd(); c.trap_ack = 1'b1; c.exp[E_TRAP] = 1'b1; c.cause = cause;
    q.push_back(c);
    q.push_back(idle_cyc(1'b1));
  endtask

  task automatic after_retire(input logic re);
    if (!re) begin
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) q.push_back(idle_cyc(1'b0));
      q.push_back(idle_cyc(1'b1));
    end
  endtask

  // Expected trace of one instruction, starting in FETCH. fw/dw >= TIMEOUT
  // means the memory never answers.
  task automatic gen_instr(input int kind, input int fw, input int dw, input logic taken,
                           input logic re, input int hold, input logic extra);
    cyc_t c;
    logic rw, mr, mw, br, j;
    int   nw;
    rw = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JAL) || (kind == K_BRW);
    mr = (kind == K_LOAD);
    mw = (kind == K_STORE);
    br = (kind == K_BR) || (kind == K_BRW);
    j  = (kind == K_JAL);
    nw = (fw >= TIMEOUT) ? TIMEOUT : fw;
    for (int k = 0; k < nw; k++) begin
      c = rnd(); c.imem_ready = 1'b0; c.exp[E_IMEM] = 1'b1; q.push_back(c);
    end
    if (fw >= TIMEOUT) begin
      do_trap(2'd3, hold);
      return;
    end
    c = rnd(); c.imem_ready = 1'b1; c.exp[E_IMEM] = 1'b1; c.exp[E_IR] = 1'b1;
    q.push_back(c);
    // decode
    c = rnd();
    c.d_il = (kind == K_ILL);
    c.d_ec = (kind == K_ECALL) || ((kind == K_ILL) && extra);
    c.d_eb = (kind == K_EBRK) || (((kind == K_ILL) || (kind == K_ECALL)) && extra);
    if (kind < K_ILL || kind == K_BRW) begin
      c.d_rw = rw; c.d_mr = mr; c.d_mw = mw; c.d_br = br; c.d_j = j;
    end
    q.push_back(c);
    if (kind == K_ILL)   begin do_trap(2'd0, hold); return; end
    if (kind == K_ECALL) begin do_trap(2'd1, hold); return; end
    if (kind == K_EBRK)  begin do_trap(2'd2, hold); return; end
    // exec
    c = rnd(); c.taken = taken;
    if (!(mr || mw) && !rw) begin
      c.run_en = re; c.exp[E_PCWE] = 1'b1; c.exp[E_PCSEL] = j | (br & taken);
      q.push_back(c); m_cnt++; after_retire(re);
      return;
    end
    q.push_back(c);
    if (mr || mw) begin
      nw = (dw >= TIMEOUT) ? TIMEOUT : dw;
      for (int k = 0; k < nw; k++) begin
        c = rnd(); c.dmem_ready = 1'b0; c.exp[E_DREQ] = 1'b1; c.exp[E_DWE] = mw;
        q.push_back(c);
      end
      if (dw >= TIMEOUT) begin
        do_trap(2'd3, hold);
        return;
      end
      c = rnd(); c.dmem_ready = 1'b1; c.exp[E_DREQ] = 1'b1; c.exp[E_DWE] = mw;
      if (!mr) begin
        c.run_en = re; c.exp[E_PCWE] = 1'b1;
        q.push_back(c); m_cnt++; after_retire(re);
        return;
      end
      q.push_back(c);
    end
    // write-back
    c = rnd(); c.run_en = re;
    c.exp[E_RF] = rw; c.exp[E_PCWE] = 1'b1; c.exp[E_PCSEL] = j | (br & taken);
    q.push_back(c); m_cnt++; after_retire(re);
  endtask

  function automatic logic [8:0] obs_vec();
    return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we,
            bus.pc_we, bus.pc_sel, bus.trap_valid, bus.busy};
  endfunction

  task automatic drive(input cyc_t c);
    bus.run_en        = c.run_en;
    bus.imem_ready    = c.imem_ready;
    bus.dmem_ready    = c.dmem_ready;
    bus.trap_ack      = c.trap_ack;
    bus.branch_taken  = c.taken;
    bus.dec_reg_write = c.d_rw;
    bus.dec_mem_read  = c.d_mr;
    bus.dec_mem_write = c.d_mw;
    bus.dec_branch    = c.d_br;
    bus.dec_jump      = c.d_j;
    bus.dec_ecall     = c.d_ec;
    bus.dec_ebreak    = c.d_eb;
    bus.dec_illegal   = c.d_il;
  endtask

  task automatic check_cyc(input cyc_t c);
    checks++;
    assert (obs_vec() === c.exp) else begin
      errors++;
      $error("FAIL outputs step %0d observed %b expected %b", step, obs_vec(), c.exp);
    end
    checks++;
    assert (bus.trap_cause === c.cause) else begin
      errors++;
      $error("FAIL trap_cause step %0d observed %0d expected %0d", step, bus.trap_cause, c.cause);
    end
    checks++;
    assert (bus.instret_count === c.cnt) else begin
      errors++;
      $error("FAIL instret step %0d observed %0d expected %0d", step, bus.instret_count, c.cnt);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge per cycle.
  task automatic play_n(input int n);
    cyc_t c;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      c = q.pop_front();
      drive(c);
      #1;
      check_cyc(c);
      step++;
      @(negedge clk);
    end
  endtask

  task automatic play();
    play_n(q.size());
  endtask

  initial begin
    cyc_t c;
    rst_n = 1'b0;
    drive('0);
    @(negedge clk);
    // Reset state under random inputs.
    for (int k = 0; k < 3; k++) q.push_back(idle_cyc(1'($urandom)));
    play();
    rst_n = 1'b1;
    q.push_back(idle_cyc(1'b0));
    q.push_back(idle_cyc(1'b1));
    play();

    // Directed: ALU op, 2-wait load, taken branch, illegal, ecall, fetch timeout.
    gen_instr(K_ALU,   0, 0, 1'b0, 1'b1, 0, 1'b0); play();
    gen_instr(K_LOAD,  0, 2, 1'b0, 1'b1, 0, 1'b0); play();
    gen_instr(K_BR,    0, 0, 1'b1, 1'b1, 0, 1'b0); play();
    gen_instr(K_ILL,   0, 0, 1'b0, 1'b1, 4, 1'b1); play();
    gen_instr(K_ECALL, 0, 0, 1'b0, 1'b1, 4, 1'b0); play();
    gen_instr(K_ALU, TIMEOUT, 0, 1'b0, 1'b1, 2, 1'b0); play();
    gen_instr(K_STORE, 1, TIMEOUT, 1'b0, 1'b1, 1, 1'b0); play();

    // Randomised instruction stream.
    for (int i = 0; i < 150; i++) begin
      int kind, fw, dw;
      kind = $urandom_range(0, 9);
      fw   = ($urandom_range(0, 19) == 0) ? TIMEOUT : $urandom_range(0, 3);
      dw   = ($urandom_range(0, 19) == 0) ? TIMEOUT : $urandom_range(0, 3);
      gen_instr(kind, fw, dw, 1'($urandom), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 4), 1'($urandom));
      play();
    end

    // Reset in the middle of a load's MEM wait.
    gen_instr(K_LOAD, 0, 3, 1'b0, 1'b1, 0, 1'b0);
    play_n(4);
    c = q.pop_front();
    drive(c);
    #1;
    check_cyc(c);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_cnt = '0;
    c = '0;
    check_cyc(c);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(idle_cyc(1'b1));
    play();

    // run_en dropped at the EXEC retire: back to IDLE, not busy.
    gen_instr(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b0); play();
    gen_instr(K_ALU, 1, 0, 1'b0, 1'b0, 0, 1'b0); play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
